// File: rtl/uart_rx_framed.sv
// UART receiver with configurable data width, optional parity and one or two stop bits.
// Received words are held in an output register with a valid/ready handshake and a sticky overrun flag.
module uart_rx_framed #(
  parameter int CLOCKS_PER_BIT      = 434,
  parameter int CLOCK_COUNTER_WIDTH = 10,
  parameter int DATA_WIDTH          = 8,
  parameter int PARITY_MODE         = 0,
  parameter int STOP_BITS           = 1
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_RX,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_parity_error,
  output logic                  o_framing_error,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] TIMER_HALF = CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] TIMER_LAST = CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] TIMER_ONE  = CLOCK_COUNTER_WIDTH'(1);
  localparam logic [3:0]                     LAST_DATA  = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]                     LAST_STOP  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                         r_state;
  logic                           r_sync1;
  logic                           r_sync2;
  logic                           r_rxPrev;
  logic [CLOCK_COUNTER_WIDTH-1:0] r_timer;
  logic [3:0]                     r_bitCount;
  logic [DATA_WIDTH-1:0]          r_shift;
  logic                           r_parityErr;
  logic                           r_frameErr;
  logic                           r_busy;
  logic [DATA_WIDTH-1:0]          r_data;
  logic                           r_valid;
  logic                           r_parityErrOut;
  logic                           r_frameErrOut;
  logic                           r_overrun;

  logic w_rx;
  logic w_timerDone;
  logic w_dataXor;
  logic w_parityErr;
  logic w_frameErr;
  logic w_complete;

  assign w_rx        = r_sync2;
  assign w_timerDone = (r_timer == TIMER_LAST);
  assign w_dataXor   = ^r_shift;
  assign w_parityErr = (PARITY_MODE == 2) ? ~(w_dataXor ^ w_rx) : (w_dataXor ^ w_rx);
  assign w_frameErr  = r_frameErr | ~w_rx;
  assign w_complete  = (r_state == STOP) && w_timerDone && (r_bitCount == LAST_STOP);

  // Synchronizer and previous-sample flops all rest high so a reset never looks like a start edge.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= i_RX;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_bitCount  <= '0;
      r_shift     <= '0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_rxPrev && !w_rx) begin
            r_state <= START;
            r_timer <= '0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (r_timer == TIMER_HALF) begin
            r_timer <= '0;
            if (w_rx) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state     <= DATA;
              r_bitCount  <= '0;
              r_parityErr <= 1'b0;
              r_frameErr  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        DATA: begin
          if (w_timerDone) begin
            r_timer <= '0;
            r_shift <= {w_rx, r_shift[DATA_WIDTH-1:1]};
            if (r_bitCount == LAST_DATA) begin
              r_bitCount <= '0;
              r_state    <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              r_bitCount <= r_bitCount + 4'd1;
            end
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        PARITY: begin
          if (w_timerDone) begin
            r_timer     <= '0;
            r_parityErr <= w_parityErr;
            r_state     <= STOP;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        STOP: begin
          if (w_timerDone) begin
            r_timer    <= '0;
            r_frameErr <= w_frameErr;
            if (r_bitCount == LAST_STOP) begin
              r_bitCount <= '0;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_bitCount <= r_bitCount + 4'd1;
            end
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // A completing frame is either delivered or dropped; consumption only matters when nothing completes.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      r_data         <= '0;
      r_valid        <= 1'b0;
      r_parityErrOut <= 1'b0;
      r_frameErrOut  <= 1'b0;
      r_overrun      <= 1'b0;
    end else if (w_complete) begin
      if (!r_valid || i_ready) begin
        r_data         <= r_shift;
        r_parityErrOut <= r_parityErr;
        r_frameErrOut  <= w_frameErr;
        r_valid        <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data          = r_data;
  assign o_valid         = r_valid;
  assign o_parity_error  = r_parityErrOut;
  assign o_framing_error = r_frameErrOut;
  assign o_overrun       = r_overrun;
  assign o_busy          = r_busy;

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 434, meaning i_clock cycles per UART bit; minimum 4.
REQ-002 SHALL have parameter CLOCK_COUNTER_WIDTH, default 10, meaning bit-timer width; it must hold CLOCKS_PER_BIT-1.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-006 SHALL have port i_clock, input, 1, the single clock.
REQ-007 SHALL have port i_resetL, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_RX, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port i_ready, input, 1, consumer accepts o_data when high with o_valid.
REQ-010 SHALL have port o_data, output, DATA_WIDTH, last received word, LSB received first.
REQ-011 SHALL have port o_valid, output, 1, o_data holds an unconsumed word.
REQ-012 SHALL have port o_parity_error, output, 1, parity mismatch for the word in o_data.
REQ-013 SHALL have port o_framing_error, output, 1, a stop bit sampled low for the word in o_data.
REQ-014 SHALL have port o_overrun, output, 1, sticky flag: a completed frame was dropped.
REQ-015 SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL pass i_RX through a 2-flop synchronizer, both flops resetting to 1; all logic uses the synchronized value rx_s.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: SHALL enter START on a falling edge of rx_s (previous 1, current 0); a line held low does not retrigger.
REQ-019 START: at bit-timer count CLOCKS_PER_BIT/2-1 SHALL sample rx_s; 1 -> IDLE (glitch, no flags), 0 -> DATA with timer cleared.
REQ-020 DATA: SHALL sample rx_s every CLOCKS_PER_BIT cycles into a shift register, LSB first; after DATA_WIDTH samples -> PARITY if PARITY_MODE!=0, else STOP.
REQ-021 PARITY: SHALL sample one bit after CLOCKS_PER_BIT cycles; error when (XOR of data bits XOR parity bit) is 1 for even or 0 for odd; -> STOP.
REQ-022 STOP: SHALL sample STOP_BITS bits at CLOCKS_PER_BIT spacing; any low sample sets the frame's framing error; after the last sample -> IDLE.
REQ-023 The frame SHALL complete on the clock edge of the last stop-bit sample; o_data, o_valid and error flags update on that edge.
REQ-024 On completion with o_valid=0, or o_valid=1 and i_ready=1 in that cycle: SHALL load o_data and both error flags, and o_valid is 1.
REQ-025 On completion with o_valid=1 and i_ready=0: SHALL discard the new frame, retain o_data and flags, and set o_overrun.
REQ-026 When o_valid=1 and i_ready=1 with no completion: SHALL clear o_valid next edge; o_data and error flags hold their values.
REQ-027 o_overrun SHALL clear only on reset; a frame with errors is still delivered.
REQ-028 The bit timer SHALL wrap from CLOCKS_PER_BIT-1 to 0 with no dropped or extra cycles; the total frame length is exact.

Reset
REQ-029 i_resetL=0 SHALL asynchronously force IDLE, timer/bit counters 0, shift register 0, synchronizer flops 1, o_data 0, o_valid 0, o_parity_error 0, o_framing_error 0, o_overrun 0, o_busy 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no output; the first falling edge after release starts a new frame normally.

Verification (CLOCKS_PER_BIT=16, CLOCK_COUNTER_WIDTH=5)
REQ-031 Defaults other than above, i_ready=0, send 0xA5 8N1 -> o_data=0xA5, o_valid=1, all flags 0; pulse i_ready -> o_valid=0 next cycle.
REQ-032 PARITY_MODE=1, send 0x03 with parity bit 1 -> o_data=0x03, o_parity_error=1; resend with parity bit 0 -> o_parity_error=0.
REQ-033 Send 0x55 with the stop bit driven low -> o_data=0x55, o_framing_error=1; hold the line low 40 cycles -> no new frame until a rising then falling edge.
REQ-034 i_RX low pulse of 4 cycles -> START returns to IDLE, o_valid stays 0, o_busy drops within 12 cycles.
REQ-035 i_ready=0, send 0x11 then 0x22 -> o_data=0x11, o_overrun=1; repeat with i_ready=1 on the completion cycle -> o_data=0x22, o_valid=1, o_overrun unchanged.
REQ-036 Assert i_resetL=0 during the 4th data bit of 0xFF -> all outputs 0; after release send 0x3C -> o_data=0x3C, o_valid=1.
